// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: bus types, tag-ownership types and address helper.
// NUM_MEM_TAGS sizes the memory tag space; tag 0 always means "no tag".
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_req_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int BLOCK_W = 64;
    localparam int TAG_W   = $clog2(`NUM_MEM_TAGS + 1);

    typedef logic [ADDR_W-1:0]  ADDR;
    typedef logic [BLOCK_W-1:0] MEM_BLOCK;
    typedef logic [TAG_W-1:0]   MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic valid;
        ADDR  addr;
    } I_ADDR_PACKET;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
    } TAG_OWNER_ENTRY;

    // Memory works on 8-byte blocks, so the low three address bits never reach the bus.
    function automatic ADDR block_align(input ADDR a);
        return a & ~ADDR'(3'b111);
    endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Records which requester owns each in-flight memory tag; lookup is combinational on the
// current contents, and a same-cycle write to the looked-up tag takes precedence over its clear.
module mem_tag_owner_table
    import mem_req_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = `NUM_MEM_TAGS
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     wr_en,
    input  MEM_TAG   wr_tag,
    input  MEM_OWNER wr_owner,
    input  MEM_TAG   lookup_tag,
    output logic     hit,
    output MEM_OWNER hit_owner
);

    logic [NUM_TAGS:1] hit_vec;
    logic [NUM_TAGS:1] owner_vec;

    generate
        for (genvar gi = 1; gi <= NUM_TAGS; gi++) begin : g_entry
            TAG_OWNER_ENTRY entry_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_reg <= '{valid: 1'b0, owner: ICACHE};
                end else if (wr_en && (wr_tag == MEM_TAG'(gi))) begin
                    entry_reg <= '{valid: 1'b1, owner: wr_owner};
                end else if (hit_vec[gi]) begin
                    entry_reg.valid <= 1'b0;
                end
            end

            assign hit_vec[gi]   = entry_reg.valid && (lookup_tag == MEM_TAG'(gi));
            assign owner_vec[gi] = (entry_reg.owner == DCACHE);
        end
    endgenerate

    // At most one entry matches, so OR-reducing the masked owner bits selects its owner.
    assign hit       = |hit_vec;
    assign hit_owner = MEM_OWNER'(|(hit_vec & owner_vec));

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the single memory request port between icache and dcache and routes returning data tags.
// Optional ARB_ICACHE_THROTTLE_EN caps icache in-flight loads at ICACHE_MAX_OUTSTANDING.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT           = 4,
    parameter int ICACHE_MAX_OUTSTANDING = 8,
    parameter int NUM_TAGS               = `NUM_MEM_TAGS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  I_ADDR_PACKET                  icache_req,
    output logic                          icache_req_accepted,
    input  logic                          dcache_req_valid,
    input  MEM_COMMAND                    dcache_req_cmd,
    input  ADDR                           dcache_req_addr,
    input  MEM_BLOCK                      dcache_req_data,
    output logic                          dcache_req_accepted,
    output MEM_COMMAND                    proc2mem_command,
    output ADDR                           proc2mem_addr,
    output MEM_BLOCK                      proc2mem_data,
    input  MEM_TAG                        mem2proc_transaction_tag,
    input  MEM_TAG                        mem2proc_data_tag,
    output MEM_TAG                        icache_data_tag,
    output MEM_TAG                        dcache_data_tag,
    output logic [$clog2(NUM_TAGS+1)-1:0] icache_outstanding
);

    localparam int OUT_W    = $clog2(NUM_TAGS + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

`ifdef ARB_ICACHE_THROTTLE_EN
    localparam bit THROTTLE_ON = 1'b1;
`else
    localparam bit THROTTLE_ON = 1'b0;
`endif

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [OUT_W-1:0]    icache_outstanding_reg;

    logic     at_cap;
    logic     starved;
    logic     icache_active;
    logic     icache_grant;
    logic     dcache_grant;
    logic     mem_accept;
    logic     table_wr_en;
    MEM_OWNER table_wr_owner;
    logic     table_hit;
    MEM_OWNER table_owner;
    logic     icache_return;

    assign at_cap        = int'(icache_outstanding_reg) >= ICACHE_MAX_OUTSTANDING;
    assign starved       = int'(starve_cnt_reg) == STARVE_LIMIT;
    assign icache_active = icache_req.valid && !(THROTTLE_ON && at_cap);

    // Grants are held off during reset so every output sits at its idle value.
    assign icache_grant = !reset && icache_active && (!dcache_req_valid || starved);
    assign dcache_grant = !reset && dcache_req_valid && !icache_grant;
    assign mem_accept   = (mem2proc_transaction_tag != '0);

    assign icache_req_accepted = icache_grant && mem_accept;
    assign dcache_req_accepted = dcache_grant && mem_accept;

    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (icache_grant) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = block_align(icache_req.addr);
        end else if (dcache_grant) begin
            proc2mem_command = dcache_req_cmd;
            proc2mem_addr    = block_align(dcache_req_addr);
            if (dcache_req_cmd == MEM_STORE) begin
                proc2mem_data = dcache_req_data;
            end
        end
    end

    // Stores never return data, so only accepted loads claim a tag.
    assign table_wr_en    = (icache_req_accepted || dcache_req_accepted) && (proc2mem_command == MEM_LOAD);
    assign table_wr_owner = icache_grant ? ICACHE : DCACHE;

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_owner_table (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (table_wr_en),
        .wr_tag     (mem2proc_transaction_tag),
        .wr_owner   (table_wr_owner),
        .lookup_tag (mem2proc_data_tag),
        .hit        (table_hit),
        .hit_owner  (table_owner)
    );

    assign icache_return   = table_hit && (table_owner == ICACHE);
    assign icache_data_tag = (!reset && icache_return) ? mem2proc_data_tag : '0;
    assign dcache_data_tag = (!reset && table_hit && (table_owner == DCACHE)) ? mem2proc_data_tag : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_reg         <= '0;
            icache_outstanding_reg <= '0;
        end else begin
            if (!icache_active || icache_req_accepted) begin
                starve_cnt_reg <= '0;
            end else if (!starved) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end

            case ({icache_req_accepted, icache_return})
                2'b10: begin
                    if (icache_outstanding_reg != '1) begin
                        icache_outstanding_reg <= icache_outstanding_reg + 1'b1;
                    end
                end
                2'b01: begin
                    assert (icache_outstanding_reg != '0);
                    if (icache_outstanding_reg != '0) begin
                        icache_outstanding_reg <= icache_outstanding_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign icache_outstanding = icache_outstanding_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a tag-ownership model.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int NT   = `NUM_MEM_TAGS;
    localparam int SL   = 4;
    localparam int IMAX = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    I_ADDR_PACKET           icache_req = '0;
    logic                   icache_req_accepted;
    logic                   dcache_req_valid = 1'b0;
    MEM_COMMAND             dcache_req_cmd = MEM_LOAD;
    ADDR                    dcache_req_addr = '0;
    MEM_BLOCK               dcache_req_data = '0;
    logic                   dcache_req_accepted;
    MEM_COMMAND             proc2mem_command;
    ADDR                    proc2mem_addr;
    MEM_BLOCK               proc2mem_data;
    MEM_TAG                 mem2proc_transaction_tag = '0;
    MEM_TAG                 mem2proc_data_tag = '0;
    MEM_TAG                 icache_data_tag;
    MEM_TAG                 dcache_data_tag;
    logic [$clog2(NT+1)-1:0] icache_outstanding;

    always #5 clock = ~clock;

    mem_req_arbiter #(
        .STARVE_LIMIT           (SL),
        .ICACHE_MAX_OUTSTANDING (IMAX),
        .NUM_TAGS               (NT)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .icache_req               (icache_req),
        .icache_req_accepted      (icache_req_accepted),
        .dcache_req_valid         (dcache_req_valid),
        .dcache_req_cmd           (dcache_req_cmd),
        .dcache_req_addr          (dcache_req_addr),
        .dcache_req_data          (dcache_req_data),
        .dcache_req_accepted      (dcache_req_accepted),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .icache_data_tag          (icache_data_tag),
        .dcache_data_tag          (dcache_data_tag),
        .icache_outstanding       (icache_outstanding)
    );

    int errors = 0;
    int checks = 0;

    // Model state after the most recent clock edge: owner per tag (0 none, 1 icache, 2 dcache).
    int m_own [0:NT];
    int m_starve = 0;
    int m_out    = 0;
    bit prev_reset = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : compare
        bit iv, ig, dg, acc_i, acc_d;
        int tt, dt, ri, rd, ecmd;
        logic [31:0] eaddr;
        logic [63:0] edata;
        if (reset) begin
            chk("rst_cmd", proc2mem_command, MEM_NONE);
            chk("rst_addr", proc2mem_addr, 0);
            chk("rst_data", proc2mem_data, 0);
            chk("rst_acc", {icache_req_accepted, dcache_req_accepted}, 0);
            chk("rst_tags", {icache_data_tag, dcache_data_tag}, 0);
            if (prev_reset) chk("rst_outstanding", icache_outstanding, 0);
            for (int t = 0; t <= NT; t++) m_own[t] = 0;
            m_starve = 0;
            m_out    = 0;
        end else begin
            iv = icache_req.valid;
`ifdef ARB_ICACHE_THROTTLE_EN
            if (m_out >= IMAX) iv = 1'b0;
`endif
            ig = iv && (!dcache_req_valid || m_starve == SL);
            dg = dcache_req_valid && !ig;
            tt = int'(mem2proc_transaction_tag);
            dt = int'(mem2proc_data_tag);
            ecmd  = ig ? int'(MEM_LOAD) : (dg ? int'(dcache_req_cmd) : int'(MEM_NONE));
            eaddr = ig ? (icache_req.addr & ~32'h7) : (dg ? (dcache_req_addr & ~32'h7) : 32'h0);
            edata = (dg && dcache_req_cmd == MEM_STORE) ? dcache_req_data : 64'h0;
            acc_i = ig && tt != 0;
            acc_d = dg && tt != 0;
            ri = (dt != 0 && m_own[dt] == 1) ? dt : 0;
            rd = (dt != 0 && m_own[dt] == 2) ? dt : 0;

            chk("cmd", proc2mem_command, ecmd);
            chk("addr", proc2mem_addr, eaddr);
            chk("data", proc2mem_data, edata);
            chk("icache_acc", icache_req_accepted, acc_i);
            chk("dcache_acc", dcache_req_accepted, acc_d);
            chk("icache_data_tag", icache_data_tag, ri);
            chk("dcache_data_tag", dcache_data_tag, rd);
            chk("outstanding", icache_outstanding, m_out);
            if (acc_i || acc_d)
                $display("txn t=%0t %s cmd=%0d addr=%h tag=%0d ret_i=%0d ret_d=%0d",
                         $time, acc_i ? "icache" : "dcache", ecmd, eaddr, tt, ri, rd);

            if (dt != 0) m_own[dt] = 0;
            if ((acc_i || acc_d) && ecmd == int'(MEM_LOAD)) m_own[tt] = acc_i ? 1 : 2;
            m_out = m_out + (acc_i ? 1 : 0) - (ri != 0 ? 1 : 0);
            if (!iv || acc_i) m_starve = 0;
            else if (m_starve < SL) m_starve++;
        end
        prev_reset = reset;
    end

    task automatic drive(input bit iv, input logic [31:0] ia, input bit dv, input MEM_COMMAND dc,
                         input logic [31:0] da, input logic [63:0] dd, input int tt, input int dt);
        @(posedge clock);
        #1;
        icache_req.valid         = iv;
        icache_req.addr          = ia;
        dcache_req_valid         = dv;
        dcache_req_cmd           = dc;
        dcache_req_addr          = da;
        dcache_req_data          = dd;
        mem2proc_transaction_tag = MEM_TAG'(tt);
        mem2proc_data_tag        = MEM_TAG'(dt);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, MEM_LOAD, 32'h0, 64'h0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        icache_req = '0;
        dcache_req_valid = 1'b0;
        mem2proc_transaction_tag = '0;
        mem2proc_data_tag = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Dcache has priority; its tag returns to it alone.
        drive(1, 32'h1000, 1, MEM_LOAD, 32'h2000, 64'h0, 3, 0);
        chk("prio_addr", proc2mem_addr, 32'h2000);
        chk("prio_dacc", dcache_req_accepted, 1);
        chk("prio_iacc", icache_req_accepted, 0);
        idle();
        drive(0, 32'h0, 0, MEM_LOAD, 32'h0, 64'h0, 0, 3);
        chk("prio_dtag", dcache_data_tag, 3);
        chk("prio_itag", icache_data_tag, 0);

        // Stores drive data and never claim a tag.
        drive(0, 32'h0, 1, MEM_STORE, 32'h300f, 64'hDEAD_BEEF_0123_4567, 5, 0);
        chk("store_cmd", proc2mem_command, MEM_STORE);
        chk("store_addr", proc2mem_addr, 32'h3008);
        chk("store_data", proc2mem_data, 64'hDEAD_BEEF_0123_4567);
        drive(0, 32'h0, 0, MEM_LOAD, 32'h0, 64'h0, 0, 5);
        chk("store_tags", {icache_data_tag, dcache_data_tag}, 0);

        // Starvation: icache wins on its fifth contested cycle, then dcache wins again.
        for (int k = 1; k <= 6; k++) begin
            drive(1, 32'h4004, 1, MEM_STORE, 32'h5000, 64'h55, 6, 0);
            if (k == 5) begin
                chk("starve_iacc", icache_req_accepted, 1);
                chk("starve_addr", proc2mem_addr, 32'h4000);
            end else begin
                chk("starve_dacc", dcache_req_accepted, 1);
            end
        end
        drive(0, 32'h0, 0, MEM_LOAD, 32'h0, 64'h0, 0, 6);
        chk("starve_ret", icache_data_tag, 6);

        // Rejected icache requests still build up starvation.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 32'h6000, 0, MEM_LOAD, 32'h0, 64'h0, 0, 0);
            chk("rej_cmd", proc2mem_command, MEM_LOAD);
            chk("rej_iacc", icache_req_accepted, 0);
        end
        drive(1, 32'h6000, 1, MEM_LOAD, 32'h7000, 64'h0, 0, 0);
        chk("rej_starved_addr", proc2mem_addr, 32'h6000);
        drive(1, 32'h6000, 1, MEM_LOAD, 32'h7000, 64'h0, 7, 0);
        chk("rej_starved_iacc", icache_req_accepted, 1);
        idle();
        chk("rej_outstanding", icache_outstanding, 1);
        drive(0, 32'h0, 0, MEM_LOAD, 32'h0, 64'h0, 0, 7);
        chk("rej_ret", icache_data_tag, 7);

        // Same tag returned to icache and re-accepted for dcache in one cycle.
        drive(1, 32'h8000, 0, MEM_LOAD, 32'h0, 64'h0, 4, 0);
        drive(0, 32'h0, 1, MEM_LOAD, 32'h9000, 64'h0, 4, 4);
        chk("coll_itag", icache_data_tag, 4);
        chk("coll_dtag", dcache_data_tag, 0);
        drive(0, 32'h0, 0, MEM_LOAD, 32'h0, 64'h0, 0, 4);
        chk("coll_new_owner", dcache_data_tag, 4);
        chk("coll_outstanding", icache_outstanding, 0);

        // Icache cap.
        drive(1, 32'hA000, 0, MEM_LOAD, 32'h0, 64'h0, 1, 0);
        drive(1, 32'hA008, 0, MEM_LOAD, 32'h0, 64'h0, 2, 0);
        idle();
        chk("thr_outstanding", icache_outstanding, 2);
        drive(1, 32'hA010, 0, MEM_LOAD, 32'h0, 64'h0, 3, 0);
`ifdef ARB_ICACHE_THROTTLE_EN
        chk("thr_cmd", proc2mem_command, MEM_NONE);
        chk("thr_iacc", icache_req_accepted, 0);
        drive(1, 32'hA010, 0, MEM_LOAD, 32'h0, 64'h0, 3, 1);
        chk("thr_ret", icache_data_tag, 1);
        drive(1, 32'hA010, 0, MEM_LOAD, 32'h0, 64'h0, 3, 0);
        chk("thr_after_outstanding", icache_outstanding, 1);
        chk("thr_after_iacc", icache_req_accepted, 1);
`else
        chk("nothr_cmd", proc2mem_command, MEM_LOAD);
        chk("nothr_iacc", icache_req_accepted, 1);
`endif

        // Reset discards ownership.
        do_reset();
        drive(1, 32'hB000, 0, MEM_LOAD, 32'h0, 64'h0, 1, 0);
        drive(1, 32'hB008, 0, MEM_LOAD, 32'h0, 64'h0, 2, 0);
        idle();
        chk("prerst_outstanding", icache_outstanding, 2);
        do_reset();
        drive(0, 32'h0, 0, MEM_LOAD, 32'h0, 64'h0, 0, 1);
        chk("postrst_tags", {icache_data_tag, dcache_data_tag}, 0);
        chk("postrst_outstanding", icache_outstanding, 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int dt, tt, start, t;
            bit found;
            if (n == 300) do_reset();
            @(negedge clock);
            #1;
            dt = 0;
            tt = 0;
            if ($urandom_range(0, 9) < 4) begin
                start = $urandom_range(1, NT);
                found = 1'b0;
                for (int j = 0; j < NT; j++) begin
                    t = ((start + j - 1) % NT) + 1;
                    if (!found && m_own[t] != 0) begin
                        dt = t;
                        found = 1'b1;
                    end
                end
            end else if ($urandom_range(0, 9) == 0) begin
                dt = $urandom_range(1, NT);
            end
            if ($urandom_range(0, 3) != 0) begin
                if (dt != 0 && $urandom_range(0, 3) == 0) begin
                    tt = dt;
                end else begin
                    start = $urandom_range(1, NT);
                    found = 1'b0;
                    for (int j = 0; j < NT; j++) begin
                        t = ((start + j - 1) % NT) + 1;
                        if (!found && m_own[t] == 0) begin
                            tt = t;
                            found = 1'b1;
                        end
                    end
                end
            end
            drive($urandom_range(0, 9) < 6, $urandom(),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? MEM_STORE : MEM_LOAD,
                  $urandom(), {$urandom(), $urandom()}, tt, dt);
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
